// File: rtl/psram_arbiter_pkg.sv
// rtl/psram_arbiter_pkg.sv - shared encodings and defaults for the psram port arbiter
package psram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_ISSUE = 2'd2,
      ST_WAIT  = 2'd3
   } arb_state_t;

   localparam logic OWNER_VID = 1'b0;
   localparam logic OWNER_CMD = 1'b1;

   localparam int DEF_ADDR_W = 24;
   localparam int DEF_DATA_W = 16;

   // The command path only beats a pending video fetch once the video streak is exhausted.
   function automatic logic cmd_wins(input logic vid_req, input logic cmd_req, input logic streak_full);
      return cmd_req && (!vid_req || streak_full);
   endfunction

endpackage

// File: rtl/psram_watchdog.sv
// rtl/psram_watchdog.sv - 8-bit transfer watchdog; expires on the cycle the count would reach TIMEOUT_CYC
module psram_watchdog #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYC - 1);
   localparam logic [7:0] MAX_CNT  = 8'(TIMEOUT_CYC);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_clear) begin
         count_d = 8'd0;
      end else if (i_enable && (count_q != MAX_CNT)) begin
         count_d = count_q + 8'd1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign o_expire = i_enable && !i_clear && (count_q == LAST_CNT);

endmodule

// File: rtl/psram_arbiter.sv
// rtl/psram_arbiter.sv - shares the psram controller port between video line fetch and the command path
module psram_arbiter
   import psram_arbiter_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int VID_BURST   = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_vid_req,
   input  logic [ADDR_W-1:0] i_vid_addr,
   output logic              o_vid_ack,
   output logic              o_vid_done,
   output logic [DATA_W-1:0] o_vid_dout,
   input  logic              i_cmd_req,
   input  logic              i_cmd_we,
   input  logic [ADDR_W-1:0] i_cmd_addr,
   input  logic [DATA_W-1:0] i_cmd_din,
   output logic              o_cmd_ack,
   output logic              o_cmd_done,
   output logic [DATA_W-1:0] o_cmd_dout,
   output logic              o_mem_stb,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_din,
   input  logic              i_mem_busy,
   input  logic              i_mem_done,
   input  logic [DATA_W-1:0] i_mem_dout,
   output logic              o_owner,
   output logic              o_timeout,
   output logic [1:0]        o_state
);

   localparam int STREAK_W = $clog2(VID_BURST + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(VID_BURST);

   arb_state_t          state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                mem_stb_q, mem_stb_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_din_q, mem_din_d;
   logic                wr_q, wr_d;
   logic                owner_q, owner_d;
   logic                vid_ack_q, vid_ack_d;
   logic                cmd_ack_q, cmd_ack_d;
   logic                vid_done_q, vid_done_d;
   logic                cmd_done_q, cmd_done_d;
   logic [DATA_W-1:0]   vid_dout_q, vid_dout_d;
   logic [DATA_W-1:0]   cmd_dout_q, cmd_dout_d;
   logic                timeout_q, timeout_d;

   logic wd_clear;
   logic wd_enable;
   logic wd_expire;
   logic grant_cmd;

   assign grant_cmd = cmd_wins(i_vid_req, i_cmd_req, streak_q == STREAK_MAX);
   assign wd_clear  = (state_q == ST_INIT) || (state_q == ST_IDLE);
   assign wd_enable = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

   psram_watchdog #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_watchdog (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (wd_clear),
      .i_enable (wd_enable),
      .o_expire (wd_expire)
   );

   always_comb begin
      state_d    = state_q;
      streak_d   = streak_q;
      mem_stb_d  = mem_stb_q;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_din_d  = mem_din_q;
      wr_d       = wr_q;
      owner_d    = owner_q;
      vid_ack_d  = 1'b0;
      cmd_ack_d  = 1'b0;
      vid_done_d = 1'b0;
      cmd_done_d = 1'b0;
      vid_dout_d = vid_dout_q;
      cmd_dout_d = cmd_dout_q;
      timeout_d  = timeout_q;

      case (state_q)
         ST_INIT: begin
            if (!i_mem_busy) begin
               state_d = ST_IDLE;
            end
         end

         ST_IDLE: begin
            if (grant_cmd) begin
               mem_stb_d  = 1'b1;
               mem_we_d   = i_cmd_we;
               mem_addr_d = i_cmd_addr;
               mem_din_d  = i_cmd_din;
               wr_d       = i_cmd_we;
               owner_d    = OWNER_CMD;
               cmd_ack_d  = 1'b1;
               streak_d   = '0;
               state_d    = ST_ISSUE;
            end else if (i_vid_req) begin
               mem_stb_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = i_vid_addr;
               mem_din_d  = '0;
               wr_d       = 1'b0;
               owner_d    = OWNER_VID;
               vid_ack_d  = 1'b1;
               state_d    = ST_ISSUE;
               // Only video grants that overtake a waiting command count towards the streak.
               if (!i_cmd_req) begin
                  streak_d = '0;
               end else if (streak_q != STREAK_MAX) begin
                  streak_d = streak_q + STREAK_W'(1);
               end
            end
         end

         ST_ISSUE, ST_WAIT: begin
            if (i_mem_done) begin
               mem_stb_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = ST_IDLE;
               if (owner_q == OWNER_CMD) begin
                  cmd_done_d = 1'b1;
                  if (!wr_q) begin
                     cmd_dout_d = i_mem_dout;
                  end
               end else begin
                  vid_done_d = 1'b1;
                  vid_dout_d = i_mem_dout;
               end
            end else if (wd_expire) begin
               // Abort: release the owner with zero data and resync on the controller going idle.
               mem_stb_d = 1'b0;
               mem_we_d  = 1'b0;
               timeout_d = 1'b1;
               state_d   = ST_INIT;
               if (owner_q == OWNER_CMD) begin
                  cmd_done_d = 1'b1;
                  cmd_dout_d = '0;
               end else begin
                  vid_done_d = 1'b1;
                  vid_dout_d = '0;
               end
            end else if ((state_q == ST_ISSUE) && i_mem_busy) begin
               mem_stb_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = ST_WAIT;
            end
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_INIT;
         streak_q   <= '0;
         mem_stb_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         wr_q       <= 1'b0;
         owner_q    <= OWNER_VID;
         vid_ack_q  <= 1'b0;
         cmd_ack_q  <= 1'b0;
         vid_done_q <= 1'b0;
         cmd_done_q <= 1'b0;
         vid_dout_q <= '0;
         cmd_dout_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         streak_q   <= streak_d;
         mem_stb_q  <= mem_stb_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_din_q  <= mem_din_d;
         wr_q       <= wr_d;
         owner_q    <= owner_d;
         vid_ack_q  <= vid_ack_d;
         cmd_ack_q  <= cmd_ack_d;
         vid_done_q <= vid_done_d;
         cmd_done_q <= cmd_done_d;
         vid_dout_q <= vid_dout_d;
         cmd_dout_q <= cmd_dout_d;
         timeout_q  <= timeout_d;
      end
   end

   assign o_vid_ack  = vid_ack_q;
   assign o_vid_done = vid_done_q;
   assign o_vid_dout = vid_dout_q;
   assign o_cmd_ack  = cmd_ack_q;
   assign o_cmd_done = cmd_done_q;
   assign o_cmd_dout = cmd_dout_q;
   assign o_mem_stb  = mem_stb_q;
   assign o_mem_we   = mem_we_q;
   assign o_mem_addr = mem_addr_q;
   assign o_mem_din  = mem_din_q;
   assign o_owner    = owner_q;
   assign o_timeout  = timeout_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// tb/tb_psram_arbiter.sv - randomized bench with a transaction-level arbitration model and psram responder
module tb_psram_arbiter;

   localparam int ADDR_W      = 24;
   localparam int DATA_W      = 16;
   localparam int VID_BURST   = 8;
   localparam int TIMEOUT_CYC = 255;
   localparam int M_QUIET     = 0;
   localparam int M_CONT      = 1;
   localparam int M_RAND      = 2;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_vid_req;
   logic [ADDR_W-1:0] i_vid_addr;
   logic              o_vid_ack;
   logic              o_vid_done;
   logic [DATA_W-1:0] o_vid_dout;
   logic              i_cmd_req;
   logic              i_cmd_we;
   logic [ADDR_W-1:0] i_cmd_addr;
   logic [DATA_W-1:0] i_cmd_din;
   logic              o_cmd_ack;
   logic              o_cmd_done;
   logic [DATA_W-1:0] o_cmd_dout;
   logic              o_mem_stb;
   logic              o_mem_we;
   logic [ADDR_W-1:0] o_mem_addr;
   logic [DATA_W-1:0] o_mem_din;
   logic              i_mem_busy;
   logic              i_mem_done;
   logic [DATA_W-1:0] i_mem_dout;
   logic              o_owner;
   logic              o_timeout;
   logic [1:0]        o_state;

   psram_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VID_BURST(VID_BURST), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_vid_req(i_vid_req), .i_vid_addr(i_vid_addr), .o_vid_ack(o_vid_ack),
      .o_vid_done(o_vid_done), .o_vid_dout(o_vid_dout),
      .i_cmd_req(i_cmd_req), .i_cmd_we(i_cmd_we), .i_cmd_addr(i_cmd_addr), .i_cmd_din(i_cmd_din),
      .o_cmd_ack(o_cmd_ack), .o_cmd_done(o_cmd_done), .o_cmd_dout(o_cmd_dout),
      .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_din(o_mem_din),
      .i_mem_busy(i_mem_busy), .i_mem_done(i_mem_done), .i_mem_dout(i_mem_dout),
      .o_owner(o_owner), .o_timeout(o_timeout), .o_state(o_state)
   );

   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   int  mode;
   bit  model_on, vack_seen, cack_seen;
   bit  xfer_active, stb_dropped, tr_hang, tr_we, tr_owner, hang_force;
   bit  timeout_seen, cur_owner, long_busy, force_busy, mbusy;
   logic [ADDR_W-1:0] tr_addr;
   logic [DATA_W-1:0] tr_din, exp_vdout, exp_cdout;
   int  ack_cyc, free_at, streak;
   logic [DATA_W-1:0] ref_mem [int];
   logic [DATA_W-1:0] mem_store [int];
   int  mem_phase, mem_wait;
   logic [ADDR_W-1:0] m_addr;
   bit  m_we;
   logic [DATA_W-1:0] m_din;
   bit  wins[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
      return a[15:0] ^ 16'hC3A5;
   endfunction

   function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
   endfunction

   task automatic reset_model();
      xfer_active = 0; stb_dropped = 0; tr_hang = 0; hang_force = 0;
      streak = 0; cur_owner = 0; timeout_seen = 0;
      exp_vdout = '0; exp_cdout = '0;
      mem_phase = 0; mem_wait = 0; mbusy = 0; long_busy = 0;
      i_mem_busy = 1'b0; i_mem_done = 1'b0;
   endtask

   task automatic observe();
      bit exp_ack, win_cmd, exp_done, ex_stb;
      int exp_state;
      vack_seen = o_vid_ack;
      cack_seen = o_cmd_ack;
      if (xfer_active && i_mem_busy) stb_dropped = 1;
      exp_done = xfer_active && (tr_hang ? (cyc == ack_cyc + TIMEOUT_CYC) : i_mem_done);
      check("vid_done", o_vid_done, exp_done && !tr_owner);
      check("cmd_done", o_cmd_done, exp_done && tr_owner);
      if (exp_done) begin
         xfer_active = 0;
         if (tr_hang) begin
            timeout_seen = 1;
            free_at = cyc + 2;
            if (tr_owner) exp_cdout = '0; else exp_vdout = '0;
         end else begin
            free_at = cyc + 1;
            if (tr_we) ref_mem[int'(tr_addr)] = tr_din;
            else if (tr_owner) exp_cdout = ref_rd(tr_addr);
            else exp_vdout = ref_rd(tr_addr);
         end
      end
      exp_ack = !xfer_active && (cyc >= free_at) && (i_vid_req || i_cmd_req);
      win_cmd = i_cmd_req && (!i_vid_req || streak == VID_BURST);
      check("vid_ack", o_vid_ack, exp_ack && !win_cmd);
      check("cmd_ack", o_cmd_ack, exp_ack && win_cmd);
      if (exp_ack) begin
         tr_owner = win_cmd;
         tr_addr  = win_cmd ? i_cmd_addr : i_vid_addr;
         tr_we    = win_cmd && i_cmd_we;
         tr_din   = win_cmd ? i_cmd_din : '0;
         cur_owner = win_cmd;
         ack_cyc = cyc;
         xfer_active = 1;
         stb_dropped = 0;
         tr_hang = hang_force || (mode == M_RAND && $urandom_range(0, 149) == 0);
         hang_force = 0;
         if (win_cmd) streak = 0;
         else if (i_cmd_req) streak = (streak < VID_BURST) ? streak + 1 : streak;
         else streak = 0;
         if (mode == M_CONT) wins.push_back(win_cmd);
         check("mem_addr", o_mem_addr, tr_addr);
         check("mem_din", o_mem_din, tr_din);
      end
      ex_stb = xfer_active && !stb_dropped;
      check("mem_stb", o_mem_stb, ex_stb);
      check("mem_we", o_mem_we, ex_stb && tr_we);
      exp_state = xfer_active ? (stb_dropped ? 3 : 2) : ((cyc < free_at - 1) ? 0 : 1);
      check("state", o_state, exp_state);
      check("owner", o_owner, cur_owner);
      check("timeout", o_timeout, timeout_seen);
      check("vid_dout", o_vid_dout, exp_vdout);
      check("cmd_dout", o_cmd_dout, exp_cdout);
   endtask

   task automatic drive();
      i_mem_done = 1'b0;
      i_mem_dout = DATA_W'($urandom);
      if (mem_phase == 3) begin
         mbusy = 0;
         mem_phase = 0;
      end else if (mem_phase == 0) begin
         if (o_mem_stb && xfer_active && !tr_hang) begin
            m_addr = o_mem_addr; m_we = o_mem_we; m_din = o_mem_din;
            mem_wait = $urandom_range(0, 2);
            mem_phase = 1;
         end
      end else if (mem_phase == 1) begin
         if (mem_wait == 0) begin
            mbusy = 1;
            mem_wait = long_busy ? 4 : $urandom_range(0, 3);
            mem_phase = 2;
         end else mem_wait--;
      end
      if (mem_phase == 2) begin
         if (mem_wait == 0) begin
            i_mem_done = 1'b1;
            if (m_we) mem_store[int'(m_addr)] = m_din;
            else i_mem_dout = mem_store.exists(int'(m_addr)) ? mem_store[int'(m_addr)] : init_val(m_addr);
            mem_phase = 3;
         end else mem_wait--;
      end
      i_mem_busy = mbusy | force_busy;

      if (vack_seen) i_vid_req = 1'b0;
      if (cack_seen) i_cmd_req = 1'b0;
      if (!i_vid_req && (mode == M_CONT || (mode == M_RAND && $urandom_range(0, 2) == 0))) begin
         i_vid_req  = 1'b1;
         i_vid_addr = 24'h000100 + ADDR_W'($urandom_range(0, 15));
      end
      if (!i_cmd_req && (mode == M_CONT || (mode == M_RAND && $urandom_range(0, 3) == 0))) begin
         i_cmd_req  = 1'b1;
         i_cmd_we   = 1'($urandom_range(0, 1));
         i_cmd_addr = 24'h000100 + ADDR_W'($urandom_range(0, 15));
         i_cmd_din  = DATA_W'($urandom);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
      cyc++;
      if (model_on) observe();
      else begin
         vack_seen = 0;
         cack_seen = 0;
      end
      drive();
   endtask

   task automatic wait_idle(input int limit);
      int k = 0;
      while ((xfer_active || i_vid_req || i_cmd_req) && k < limit) begin
         step();
         k++;
      end
      if (xfer_active || i_vid_req || i_cmd_req) check("idle_wait_expired", 0, 1);
   endtask

   task automatic check_all_zero();
      check("zero_vid_ack", o_vid_ack, 0);
      check("zero_vid_done", o_vid_done, 0);
      check("zero_vid_dout", o_vid_dout, 0);
      check("zero_cmd_ack", o_cmd_ack, 0);
      check("zero_cmd_done", o_cmd_done, 0);
      check("zero_cmd_dout", o_cmd_dout, 0);
      check("zero_mem_stb", o_mem_stb, 0);
      check("zero_mem_we", o_mem_we, 0);
      check("zero_mem_addr", o_mem_addr, 0);
      check("zero_mem_din", o_mem_din, 0);
      check("zero_owner", o_owner, 0);
      check("zero_timeout", o_timeout, 0);
      check("zero_state", o_state, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit: simulation did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      i_rst = 1'b1;
      i_vid_req = 1'b0; i_vid_addr = '0;
      i_cmd_req = 1'b0; i_cmd_we = 1'b0; i_cmd_addr = '0; i_cmd_din = '0;
      i_mem_dout = '0;
      mode = M_QUIET; model_on = 0; free_at = 0;
      reset_model();
      force_busy = 1;
      i_mem_busy = 1'b1;

      // startup: controller busy for 20 cycles after reset
      repeat (3) step();
      check_all_zero();
      i_rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         check("init_state", o_state, 0);
         check("init_stb", o_mem_stb, 0);
         check("init_acks", o_vid_ack | o_cmd_ack, 0);
      end
      force_busy = 0;
      i_mem_busy = 1'b0;
      model_on = 1;
      free_at = cyc + 2;

      // both requesters held high: expect eight video grants then one command grant
      mode = M_CONT;
      for (int k = 0; k < 600 && wins.size() < 18; k++) step();
      mode = M_QUIET;
      wait_idle(300);
      check("cont_grant_count", wins.size() >= 18, 1);
      for (int k = 0; k < 18 && k < wins.size(); k++) check("cont_order", wins[k], (k % 9) == 8);

      // random traffic, first grant hangs the memory
      mode = M_RAND;
      hang_force = 1;
      repeat (4000) step();
      mode = M_QUIET;
      wait_idle(1000);
      check("timeout_sticky", o_timeout, 1);

      // reset while waiting on a command read
      i_cmd_req = 1'b1; i_cmd_we = 1'b0; i_cmd_addr = 24'h000105; i_cmd_din = '0;
      long_busy = 1;
      for (int k = 0; k < 60 && o_state != 2'd3; k++) step();
      check("reach_wait", o_state, 3);
      i_rst = 1'b1;
      #1;
      check_all_zero();
      model_on = 0;
      reset_model();
      i_vid_req = 1'b0;
      i_cmd_req = 1'b0;
      repeat (2) begin
         step();
         check("rst_no_vid_done", o_vid_done, 0);
         check("rst_no_cmd_done", o_cmd_done, 0);
      end
      i_rst = 1'b0;
      model_on = 1;
      free_at = cyc + 2;

      // command write then read back
      i_cmd_req = 1'b1; i_cmd_we = 1'b1; i_cmd_addr = 24'hABCDEF; i_cmd_din = 16'h8765;
      wait_idle(100);
      check("wr_keeps_dout", o_cmd_dout, 16'h0000);
      i_cmd_req = 1'b1; i_cmd_we = 1'b0; i_cmd_addr = 24'hABCDEF; i_cmd_din = 16'h0000;
      wait_idle(100);
      check("rd_dout", o_cmd_dout, 16'h8765);
      check("timeout_cleared", o_timeout, 0);
      repeat (3) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
